// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [1:0] CLS_ILOAD   = 2'b00;
  localparam logic [1:0] CLS_STORE   = 2'b01;
  localparam logic [1:0] CLS_RTYPE   = 2'b10;
  localparam logic [1:0] CLS_ILLEGAL = 2'b11;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_IMEM    = 2'b01;
  localparam logic [1:0] FLT_DMEM    = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL = 2'b11;

  // Class 00 splits into load / ALU-immediate on instr[4].
  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_ALUI  = 2'd1,
    OP_STORE = 2'd2,
    OP_RTYPE = 2'd3
  } op_e;

  function automatic op_e decode_op(input logic [1:0] cls, input logic imm_bit);
    case (cls)
      CLS_ILOAD: decode_op = imm_bit ? OP_ALUI : OP_LOAD;
      CLS_STORE: decode_op = OP_STORE;
      default:   decode_op = OP_RTYPE;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter; timeout_o flags the last permitted wait cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (en_i && cnt_q < LIMIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // This cycle's increment would reach MEM_TIMEOUT.
  assign timeout_o = (cnt_q >= LAST);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait watchdog.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_load,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic        wb_sel_mem,
  output logic        pc_inc,
  output logic [2:0]  state_o,
  output logic        halted,
  output logic [1:0]  fault_code
);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [1:0] fault_q, fault_d;
  logic       timeout;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:7], instr[3:0]};

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_d != state_q),
    .en_i      (state_q == ST_FETCH || state_q == ST_MEM),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      fault_q <= FLT_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    fault_d     = fault_q;
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    wb_sel_mem  = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_HALT;
          fault_d = FLT_IMEM;
        end
      end
      ST_DECODE: begin
        op_d = decode_op(instr[6:5], instr[4]);
        if (instr[6:5] == CLS_ILLEGAL) begin
          state_d = ST_HALT;
          fault_d = FLT_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_src_imm = (op_q != OP_RTYPE);
        state_d     = (op_q == OP_LOAD || op_q == OP_STORE) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        dmem_req    = 1'b1;
        dmem_we     = (op_q == OP_STORE);
        alu_src_imm = 1'b1;
        if (dmem_ready) begin
          state_d = (op_q == OP_STORE) ? ST_FETCH : ST_WB;
        end else if (timeout) begin
          state_d = ST_HALT;
          fault_d = FLT_DMEM;
        end
      end
      ST_WB: begin
        reg_we     = 1'b1;
        wb_sel_mem = (op_q == OP_LOAD);
        state_d    = ST_FETCH;
      end
      default: state_d = ST_HALT;
    endcase
  end

  assign state_o    = state_q;
  assign halted     = (state_q == ST_HALT);
  assign fault_code = fault_q;

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle control sequencer for the 8-bit processor core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and handshakes with the instruction and data memories. It decodes the class field instr[6:5], which the immediate generator also uses, and drives the register file, ALU operand mux, PC and memory strobes. A watchdog on memory waits forces a fault halt.

Parameters:
MEM_TIMEOUT, 15, maximum cycles to wait for imem_ready/dmem_ready before faulting (1..255)
CNT_W, 8, width of the wait counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  core clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
instr  in  32  instruction register contents (valid from DECODE onward)
imem_ready  in  1  instruction memory has data on its bus this cycle
dmem_ready  in  1  data memory access completes this cycle
imem_req  out  1  instruction fetch request
ir_load  out  1  load instruction register (one-cycle pulse)
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write enable (store)
alu_src_imm  out  1  ALU operand B = imm_data (1) or register (0)
reg_we  out  1  register file write (one-cycle pulse)
wb_sel_mem  out  1  writeback source: 1 = dmem read data, 0 = ALU result
pc_inc  out  1  PC increment (one-cycle pulse)
state_o  out  3  current state encoding (debug)
halted  out  1  sticky fault flag
fault_code  out  2  00 none, 01 imem timeout, 10 dmem timeout, 11 illegal class

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Reset, or rst high at any cycle including mid-access, sets state to IDLE, wait counter to 0, halted=0 and fault_code=00. All pulses are 0 on the following cycle.
- IDLE -> FETCH unconditionally on the next cycle.
- FETCH: imem_req=1. The counter increments each cycle. If imem_ready=1, assert ir_load=1 and pc_inc=1 in that same cycle, clear the counter and go to DECODE. If the counter reaches MEM_TIMEOUT with no ready, go to HALT with code 01. Ready on the timeout cycle counts as success.
- DECODE: one cycle, classified on instr[6:5].
  - 00 = load if instr[4]=0, ALU-immediate if instr[4]=1
  - 01 = store
  - 10 = R-type
  - 11 = illegal; go to HALT with code 11
  - All legal classes go to EXEC.
- EXEC: one cycle. alu_src_imm=1 for class 00 and 01, and 0 for 10. Load and store go to MEM; ALU-immediate and R-type go to WB.
- MEM: dmem_req=1, dmem_we=1 for stores only. alu_src_imm stays 1 so the address holds. The counter behaves as in FETCH.
  - On dmem_ready: a store goes to FETCH (no writeback); a load goes to WB.
  - On timeout: go to HALT with code 10.
- WB: reg_we=1 for one cycle. wb_sel_mem=1 for a load and 0 otherwise. Next state is FETCH.
- HALT: all request and pulse outputs are 0, halted=1, and fault_code holds. Only rst exits HALT.
- Outputs are Moore-decoded from the state plus the latched class, except ir_load and pc_inc, which are gated by imem_ready in FETCH.
- The instruction class is latched in DECODE and used in EXEC, MEM and WB. instr may change after DECODE without effect.
- Instruction latency with zero-wait memory:
  - load: FETCH, DEC, EXEC, MEM, WB = 5 cycles
  - store: 4 cycles
  - ALU: 4 cycles
- The counter clears on every state entry and saturates; it never wraps.

Decomposition:
- Shared package mc_pkg:
  - state enum (3-bit encodings above)
  - class constants: CLS_ILOAD=2'b00, CLS_STORE=2'b01, CLS_RTYPE=2'b10, CLS_ILLEGAL=2'b11
  - fault code constants
- Sub-module mem_wait_timer: counter with clear, enable and timeout compare, instantiated once and shared by FETCH and MEM.

Test Plan:
- rst=1 for 2 cycles, then release -> state_o 0 then 1. All pulses and halted are 0 while in reset.
- Load (instr[6:5]=00, instr[4]=0), both readys tied 1 -> states 1,2,3,4,5,1. reg_we and wb_sel_mem are both 1 only in WB. Exactly one ir_load and one pc_inc.
- Store (01), dmem_ready held low 3 cycles -> MEM lasts 4 cycles with dmem_we=1, then FETCH. reg_we is never asserted.
- R-type (10) -> alu_src_imm=0 in EXEC, reg_we=1 in the cycle after EXEC, wb_sel_mem=0.
- imem_ready never asserted with MEM_TIMEOUT=15 -> HALT after 15 FETCH cycles, fault_code=01, halted=1. A later imem_ready is ignored until rst.
- Illegal class (11) -> HALT directly from DECODE with fault_code=11. Asserting rst in MEM mid-load returns to IDLE with no reg_we.
